stdp_synapse: RTL and testbench

Plastic synapse between the presynaptic and postsynaptic LIF neurons. It consumes single-cycle spike pulses from both neurons and tracks pre/post spike timing inside a fixed window. It applies a pair-based STDP weight update with amplitudes 16-8-4-2 by time bucket. It also drives the registered synaptic current (weight on a pre spike) into the postsynaptic LIF current input.

---
 rtl/stdp_pkg.sv | 24 ++
 rtl/stdp_spike_timer.sv | 35 +++
 rtl/stdp_synapse.sv | 122 ++++++++++++
 tb/tb_stdp_synapse.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared types, defaults and the bucketed amplitude helper for the STDP synapse.
// Optional event counters are enabled with STDP_EVENT_CNT_EN.
package stdp_pkg;

   localparam int W_WIDTH_DEF = 8;
   localparam int T_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      UPD_NONE,
      UPD_LTP,
      UPD_LTD
   } upd_e;

   typedef enum logic {
      TMR_IDLE,
      TMR_ARMED
   } tmr_e;

   // Four equal-width time buckets; each halves the amplitude.
   function automatic int stdp_delta(input int dt, input int t_width, input int amp);
      return amp >> (dt >> (t_width - 2));
   endfunction

endpackage

// File: rtl/stdp_spike_timer.sv
// Counts cycles since the last own spike; expires after 2**T_WIDTH cycles.
module stdp_spike_timer
   import stdp_pkg::*;
#(
   parameter int T_WIDTH = T_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               spike,
   output logic               armed,
   output logic [T_WIDTH-1:0] count
);

   tmr_e state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= TMR_IDLE;
         count <= '0;
      end else if (spike) begin
         state <= TMR_ARMED;
         count <= '0;
      end else if (state == TMR_ARMED) begin
         if (count == '1) begin
            state <= TMR_IDLE;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   assign armed = (state == TMR_ARMED);

endmodule

// File: rtl/stdp_synapse.sv
// Pair-based STDP synapse: timing, weight update with clamping, synaptic current.
// Optional LTP/LTD event counters are enabled with STDP_EVENT_CNT_EN.
module stdp_synapse
   import stdp_pkg::*;
#(
   parameter int W_WIDTH = W_WIDTH_DEF,
   parameter int T_WIDTH = T_WIDTH_DEF,
   parameter int W_INIT  = 16,
   parameter int W_MIN   = 0,
   parameter int W_MAX   = 255,
   parameter int A_MAX   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pre_spike,
   input  logic               post_spike,
   input  logic               learn_en,
   output logic [W_WIDTH-1:0] weight,
   output logic [W_WIDTH-1:0] syn_current,
   output logic               update_w_flag,
   output logic               update_dir,
`ifdef STDP_EVENT_CNT_EN
   output logic [7:0]         ltp_count,
   output logic [7:0]         ltd_count,
`endif
   output logic [T_WIDTH-1:0] time_diff
);

   localparam logic [W_WIDTH:0]   W_MAX_X  = (W_WIDTH+1)'(W_MAX);
   localparam logic [W_WIDTH-1:0] W_MAX_W  = W_WIDTH'(W_MAX);
   localparam logic [W_WIDTH-1:0] W_MIN_W  = W_WIDTH'(W_MIN);
   localparam logic [W_WIDTH-1:0] W_INIT_W = W_WIDTH'(W_INIT);

   logic               pre_armed;
   logic               post_armed;
   logic [T_WIDTH-1:0] pre_count;
   logic [T_WIDTH-1:0] post_count;
   upd_e               upd;
   logic [T_WIDTH-1:0] dt_sel;
   logic [W_WIDTH-1:0] delta;
   logic [W_WIDTH:0]   sum;
   logic [W_WIDTH:0]   diff;
   logic [W_WIDTH-1:0] w_next;

   stdp_spike_timer #(.T_WIDTH(T_WIDTH)) u_pre_tmr (
      .clk   (clk),
      .rst   (rst),
      .spike (pre_spike),
      .armed (pre_armed),
      .count (pre_count)
   );

   stdp_spike_timer #(.T_WIDTH(T_WIDTH)) u_post_tmr (
      .clk   (clk),
      .rst   (rst),
      .spike (post_spike),
      .armed (post_armed),
      .count (post_count)
   );

   always_comb begin
      upd    = UPD_NONE;
      dt_sel = '0;
      unique case (1'b1)
         (learn_en && post_spike && !pre_spike && pre_armed): begin
            upd    = UPD_LTP;
            dt_sel = pre_count;
         end
         (learn_en && pre_spike && !post_spike && post_armed): begin
            upd    = UPD_LTD;
            dt_sel = post_count;
         end
         default: ;
      endcase
   end

   // One guard bit so overflow and borrow are visible before clamping.
   always_comb begin
      delta = W_WIDTH'(stdp_delta(int'(dt_sel), T_WIDTH, A_MAX));
      sum   = {1'b0, weight} + {1'b0, delta};
      diff  = {1'b0, weight} - {1'b0, delta};
      if (upd == UPD_LTP) begin
         w_next = (sum > W_MAX_X) ? W_MAX_W : sum[W_WIDTH-1:0];
      end else begin
         w_next = (diff[W_WIDTH] || (diff[W_WIDTH-1:0] <= W_MIN_W))
                  ? W_MIN_W : diff[W_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         weight        <= W_INIT_W;
         syn_current   <= '0;
         update_w_flag <= 1'b0;
         update_dir    <= 1'b0;
         time_diff     <= '0;
      end else begin
         syn_current   <= pre_spike ? weight : '0;
         update_w_flag <= (upd != UPD_NONE);
         if (upd != UPD_NONE) begin
            weight     <= w_next;
            update_dir <= (upd == UPD_LTP);
            time_diff  <= dt_sel;
         end
      end
   end

`ifdef STDP_EVENT_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ltp_count <= '0;
         ltd_count <= '0;
      end else begin
         if (upd == UPD_LTP && ltp_count != 8'hFF)
            ltp_count <= ltp_count + 8'd1;
         if (upd == UPD_LTD && ltd_count != 8'hFF)
            ltd_count <= ltd_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_stdp_synapse.sv
// Directed bench for stdp_synapse with hand-computed expected values.
// Counter ports are connected when STDP_EVENT_CNT_EN is defined.
module tb_stdp_synapse;

   logic       clk = 1'b0;
   logic       rst;
   logic       pre_spike;
   logic       post_spike;
   logic       learn_en;
   logic [7:0] weight;
   logic [7:0] syn_current;
   logic       update_w_flag;
   logic       update_dir;
   logic [3:0] time_diff;
`ifdef STDP_EVENT_CNT_EN
   logic [7:0] ltp_count;
   logic [7:0] ltd_count;
`endif

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   stdp_synapse dut (
      .clk           (clk),
      .rst           (rst),
      .pre_spike     (pre_spike),
      .post_spike    (post_spike),
      .learn_en      (learn_en),
      .weight        (weight),
      .syn_current   (syn_current),
      .update_w_flag (update_w_flag),
      .update_dir    (update_dir),
`ifdef STDP_EVENT_CNT_EN
      .ltp_count     (ltp_count),
      .ltd_count     (ltd_count),
`endif
      .time_diff     (time_diff)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic idle();
      repeat (20) tick();
   endtask

   // First spike, d quiet cycles, second spike; returns just after the update edge.
   task automatic pair(input logic pre_first, input int d);
      if (pre_first) pre_spike = 1'b1;
      else           post_spike = 1'b1;
      tick();
      pre_spike  = 1'b0;
      post_spike = 1'b0;
      repeat (d) tick();
      if (pre_first) post_spike = 1'b1;
      else           pre_spike = 1'b1;
      tick();
      pre_spike  = 1'b0;
      post_spike = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      pre_spike  = 1'b1;
      post_spike = 1'b0;
      learn_en   = 1'b1;
      repeat (2) tick();
      pre_spike = 1'b0;
      rst       = 1'b0;
      vectors++;
      if (weight !== 8'd16) begin
         errors++;
         $display("FAIL reset_weight got %0d want 16", weight);
      end
      vectors++;
      if (syn_current !== 8'd0) begin
         errors++;
         $display("FAIL reset_syn got %0d want 0", syn_current);
      end
      vectors++;
      if (update_w_flag !== 1'b0 || update_dir !== 1'b0) begin
         errors++;
         $display("FAIL reset_flag got %b/%b want 0/0", update_w_flag, update_dir);
      end
      vectors++;
      if (time_diff !== 4'd0) begin
         errors++;
         $display("FAIL reset_tdiff got %0d want 0", time_diff);
      end
   endtask

   task automatic test_ltp();
      do_reset();
      pair(1'b1, 3);
      vectors++;
      if (update_w_flag !== 1'b1 || update_dir !== 1'b1) begin
         errors++;
         $display("FAIL ltp_flag got %b/%b want 1/1", update_w_flag, update_dir);
      end
      vectors++;
      if (weight !== 8'd32 || time_diff !== 4'd3) begin
         errors++;
         $display("FAIL ltp_weight got %0d/%0d want 32/3", weight, time_diff);
      end
      tick();
      vectors++;
      if (update_w_flag !== 1'b0 || weight !== 8'd32 || time_diff !== 4'd3) begin
         errors++;
         $display("FAIL ltp_hold got %b/%0d/%0d want 0/32/3",
                  update_w_flag, weight, time_diff);
      end
      idle();
   endtask

   task automatic test_ltd();
      do_reset();
      pair(1'b0, 9);
      vectors++;
      if (update_w_flag !== 1'b1 || update_dir !== 1'b0) begin
         errors++;
         $display("FAIL ltd_flag got %b/%b want 1/0", update_w_flag, update_dir);
      end
      vectors++;
      if (weight !== 8'd12 || time_diff !== 4'd9) begin
         errors++;
         $display("FAIL ltd_weight got %0d/%0d want 12/9", weight, time_diff);
      end
      vectors++;
      if (syn_current !== 8'd16) begin
         errors++;
         $display("FAIL ltd_syn got %0d want 16", syn_current);
      end
      tick();
      vectors++;
      if (syn_current !== 8'd0 || update_w_flag !== 1'b0) begin
         errors++;
         $display("FAIL ltd_syn_clear got %0d/%b want 0/0", syn_current, update_w_flag);
      end
      idle();
   endtask

   task automatic test_window_edge();
      do_reset();
      pair(1'b1, 15);
      vectors++;
      if (update_w_flag !== 1'b1 || weight !== 8'd18 || time_diff !== 4'd15) begin
         errors++;
         $display("FAIL win_last got %b/%0d/%0d want 1/18/15",
                  update_w_flag, weight, time_diff);
      end
      idle();
      do_reset();
      pair(1'b1, 16);
      vectors++;
      if (update_w_flag !== 1'b0 || weight !== 8'd16) begin
         errors++;
         $display("FAIL win_expired got %b/%0d want 0/16", update_w_flag, weight);
      end
      idle();
   endtask

   task automatic test_clamp();
      do_reset();
      repeat (14) begin
         pair(1'b1, 0);
         idle();
      end
      pair(1'b1, 4);
      idle();
      pair(1'b1, 12);
      idle();
      vectors++;
      if (weight !== 8'd250) begin
         errors++;
         $display("FAIL clamp_preload got %0d want 250", weight);
      end
      pair(1'b1, 2);
      vectors++;
      if (update_w_flag !== 1'b1 || weight !== 8'd255) begin
         errors++;
         $display("FAIL clamp_max got %b/%0d want 1/255", update_w_flag, weight);
      end
      idle();
      pair(1'b1, 0);
      vectors++;
      if (update_w_flag !== 1'b1 || weight !== 8'd255) begin
         errors++;
         $display("FAIL clamp_max_hold got %b/%0d want 1/255", update_w_flag, weight);
      end
      idle();
      do_reset();
      repeat (7) begin
         pair(1'b0, 12);
         idle();
      end
      vectors++;
      if (weight !== 8'd2) begin
         errors++;
         $display("FAIL clamp_ltd_preload got %0d want 2", weight);
      end
      pair(1'b0, 1);
      vectors++;
      if (update_w_flag !== 1'b1 || update_dir !== 1'b0 || weight !== 8'd0) begin
         errors++;
         $display("FAIL clamp_min got %b/%b/%0d want 1/0/0",
                  update_w_flag, update_dir, weight);
      end
      idle();
   endtask

   task automatic test_simultaneous();
      do_reset();
      pre_spike  = 1'b1;
      post_spike = 1'b1;
      tick();
      pre_spike  = 1'b0;
      post_spike = 1'b0;
      vectors++;
      if (update_w_flag !== 1'b0 || weight !== 8'd16) begin
         errors++;
         $display("FAIL simul_noupd got %b/%0d want 0/16", update_w_flag, weight);
      end
      post_spike = 1'b1;
      tick();
      post_spike = 1'b0;
      vectors++;
      if (update_w_flag !== 1'b1 || weight !== 8'd32 || time_diff !== 4'd0) begin
         errors++;
         $display("FAIL simul_restart got %b/%0d/%0d want 1/32/0",
                  update_w_flag, weight, time_diff);
      end
      idle();
   endtask

   task automatic test_learn_off();
      do_reset();
      learn_en  = 1'b0;
      pre_spike = 1'b1;
      tick();
      pre_spike = 1'b0;
      vectors++;
      if (syn_current !== 8'd16) begin
         errors++;
         $display("FAIL frozen_syn got %0d want 16", syn_current);
      end
      repeat (2) tick();
      post_spike = 1'b1;
      tick();
      post_spike = 1'b0;
      vectors++;
      if (update_w_flag !== 1'b0 || weight !== 8'd16) begin
         errors++;
         $display("FAIL frozen_noupd got %b/%0d want 0/16", update_w_flag, weight);
      end
      learn_en = 1'b1;
      idle();
   endtask

   task automatic test_reset_mid_window();
      do_reset();
      pre_spike = 1'b1;
      tick();
      pre_spike = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      post_spike = 1'b1;
      tick();
      post_spike = 1'b0;
      vectors++;
      if (update_w_flag !== 1'b0 || weight !== 8'd16) begin
         errors++;
         $display("FAIL rst_mid got %b/%0d want 0/16", update_w_flag, weight);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_ltp();
      test_ltd();
      test_window_edge();
      test_clamp();
      test_simultaneous();
      test_learn_off();
      test_reset_mid_window();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
